seq_div_8bit: RTL and testbench
===============================

Name: seq_div_8bit

Overview:
- Sequential restoring divider for the 8-bit RISC datapath. It is the inverse of the 4x4 array multiplier: an 8-bit dividend divided by a 4-bit divisor gives an 8-bit quotient and a 4-bit remainder.
- Produces one quotient bit per clock. A start/busy/done handshake lets the ALU sequencer stall on DIV/MOD instructions.

Parameters:
- WIDTH_N, 8, dividend and quotient width
- WIDTH_D, 4, divisor and remainder width (WIDTH_D <= WIDTH_N)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  request; sampled only when not busy
- dividend  in  WIDTH_N  captured on the accepted start edge
- divisor  in  WIDTH_D  captured on the accepted start edge
- busy  out  1  high while iterating
- done  out  1  one-cycle pulse; quotient and remainder valid
- quotient  out  WIDTH_N  result, held until the next result
- remainder  out  WIDTH_D  result, held until the next result
- div_by_zero  out  1  valid with done; held with the results

Behaviour:
- Clocking and reset: one clock. Reset is synchronous and active-high (rst sampled on the clk rising edge).
- Reset values: all outputs are 0, state=IDLE, internal registers are 0.
- rst overrides everything, including mid-operation. An operation in flight is abandoned; no done is emitted.
- States: IDLE, RUN, DONE.
- Start acceptance:
  - In IDLE or DONE, start=1 at edge k is accepted.
  - Operands are latched, partial remainder R is cleared (WIDTH_D+1 bits), Q is set to the dividend, and the counter is set to WIDTH_N.
  - If divisor != 0: go to RUN, busy=1 after edge k.
- Divide by zero (divisor == 0 at edge k):
  - Skip RUN and go directly to DONE.
  - After edge k+1: done=1, quotient = all ones, remainder = dividend[WIDTH_D-1:0], div_by_zero=1.
- Each RUN edge:
  - Shift {R,Q} left by 1.
  - Compute trial = R - {0,divisor}.
  - If trial is non-negative, R=trial and Q[0]=1; otherwise restore and Q[0]=0.
  - Decrement the counter.
- RUN exit: at the edge where the counter goes 1->0 (edge k+WIDTH_N), the block enters DONE.
  - quotient<=Q, remainder<=R[WIDTH_D-1:0], div_by_zero<=0.
  - busy<=0, done<=1.
- Latency: done is high in the cycle after edge k+WIDTH_N, which is 8 cycles for the defaults. It is exactly one cycle wide.
- DONE lasts one cycle, then IDLE unless start=1 in that cycle. Back-to-back operation is allowed: the new start is accepted on the DONE edge, done drops, and busy rises.
- start while busy=1 is ignored. Operands are not re-sampled and the result is unaffected.
- quotient, remainder and div_by_zero change only on a done edge or on rst.
- Width rules:
  - The quotient can need all WIDTH_N bits (e.g. 255/1), so there is no overflow.
  - The partial remainder needs WIDTH_D+1 bits for the compare.
  - All arithmetic is unsigned.

Decomposition:
- Shared package div_pkg:
  - state encoding localparams S_IDLE=2'd0, S_RUN=2'd1, S_DONE=2'd2
  - WIDTH_N and WIDTH_D default constants
  - counter width = clog2(WIDTH_N+1)
- One natural sub-module, div_step: combinational shift, trial-subtract and restore. It is reused later for the MOD and signed variants.
- FSM and registers stay in the top module.

Test Plan:
- rst, then dividend=117 (0x75), divisor=9, start pulse -> busy for 8 cycles, then done one cycle; quotient=13, remainder=0, div_by_zero=0.
- dividend=200, divisor=7 -> quotient=28, remainder=4. Then dividend=255, divisor=1 -> quotient=255, remainder=0. Then dividend=225, divisor=15 -> quotient=15, remainder=0.
- dividend=0x55, divisor=0 -> done on the second edge after start, no busy; quotient=0xFF, remainder=0x5, div_by_zero=1.
- Start 20/2, then re-pulse start with 9/3 at cycle 3 of busy -> ignored; result is quotient=10, remainder=0. Start 9/3 during the DONE cycle -> accepted; quotient=3, remainder=0 after 8 more cycles.
- Start 117/9, assert rst at busy cycle 4 -> the next cycle has busy=0, done=0, outputs 0; no done pulse follows. A fresh 10/3 then gives quotient=3, remainder=1.
- Random sweep: all 256x16 operand pairs -> quotient and remainder match the reference model; done-to-start latency is always 8 (1 when divisor=0).

Source files
------------

// File: rtl/seq_div_8bit_pkg.sv
// rtl/seq_div_8bit_pkg.sv - shared constants, state encoding and helpers for the sequential divider
package div_pkg;

    localparam int DEF_WIDTH_N = 8;
    localparam int DEF_WIDTH_D = 4;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = S_IDLE,
        ST_RUN  = S_RUN,
        ST_DONE = S_DONE
    } state_e;

    // Counter must hold the value WIDTH_N itself, not just WIDTH_N-1.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

    localparam int DEF_CNT_W = cnt_width(DEF_WIDTH_N);

endpackage

// File: rtl/seq_div_8bit_if.sv
// rtl/seq_div_8bit_if.sv - start/busy/done handshake and operand/result bundle for the divider
interface seq_div_8bit_if #(
    parameter int WIDTH_N = div_pkg::DEF_WIDTH_N,
    parameter int WIDTH_D = div_pkg::DEF_WIDTH_D
) ();
    logic               start;
    logic [WIDTH_N-1:0] dividend;
    logic [WIDTH_D-1:0] divisor;
    logic               busy;
    logic               done;
    logic [WIDTH_N-1:0] quotient;
    logic [WIDTH_D-1:0] remainder;
    logic               div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/seq_div_8bit_step.sv
// rtl/seq_div_8bit_step.sv - one restoring-division iteration: shift, trial subtract, restore
module div_step #(
    parameter int WIDTH_N = div_pkg::DEF_WIDTH_N,
    parameter int WIDTH_D = div_pkg::DEF_WIDTH_D
) (
    input  logic [WIDTH_D:0]   r_in,
    input  logic [WIDTH_N-1:0] q_in,
    input  logic [WIDTH_D-1:0] divisor,
    output logic [WIDTH_D:0]   r_out,
    output logic [WIDTH_N-1:0] q_out
);
    localparam int RW = WIDTH_D + 2;

    logic [RW-1:0] r_wide;
    logic [RW-1:0] d_wide;
    logic          ge;

    // Extra headroom bit lets the compare see the full shifted remainder.
    assign r_wide = {r_in, q_in[WIDTH_N-1]};
    assign d_wide = {2'b00, divisor};
    assign ge     = (r_wide >= d_wide);

    assign r_out = ge ? (WIDTH_D+1)'(r_wide - d_wide) : (WIDTH_D+1)'(r_wide);
    assign q_out = {q_in[WIDTH_N-2:0], ge};
endmodule

// File: rtl/seq_div_8bit.sv
// rtl/seq_div_8bit.sv - sequential restoring divider, one quotient bit per clock
module seq_div_8bit
    import div_pkg::*;
#(
    parameter int WIDTH_N = DEF_WIDTH_N,
    parameter int WIDTH_D = DEF_WIDTH_D
) (
    input  logic          clk,
    input  logic          rst,
    seq_div_8bit_if.slave bus
);
    localparam int CNT_W = cnt_width(WIDTH_N);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH_D:0]   r_q, r_d;
    logic [WIDTH_N-1:0] q_q, q_d;
    logic [WIDTH_D-1:0] dvs_q, dvs_d;
    logic               zero_q, zero_d;
    logic               busy_q, busy_d;
    logic [WIDTH_N-1:0] quotient_q, quotient_d;
    logic [WIDTH_D-1:0] remainder_q, remainder_d;
    logic               dbz_q, dbz_d;

    logic [WIDTH_D:0]   r_nx;
    logic [WIDTH_N-1:0] q_nx;

    div_step #(.WIDTH_N(WIDTH_N), .WIDTH_D(WIDTH_D)) u_step (
        .r_in    (r_q),
        .q_in    (q_q),
        .divisor (dvs_q),
        .r_out   (r_nx),
        .q_out   (q_nx)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        r_d         = r_q;
        q_d         = q_q;
        dvs_d       = dvs_q;
        zero_d      = zero_q;
        busy_d      = busy_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (bus.start) begin
                    dvs_d   = bus.divisor;
                    q_d     = bus.dividend;
                    r_d     = '0;
                    cnt_d   = CNT_W'(WIDTH_N);
                    zero_d  = (bus.divisor == '0);
                    busy_d  = (bus.divisor != '0);
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // A zero divisor spends one non-busy cycle here so the result lands on edge k+1.
                if (zero_q) begin
                    state_d     = ST_DONE;
                    zero_d      = 1'b0;
                    quotient_d  = '1;
                    remainder_d = q_q[WIDTH_D-1:0];
                    dbz_d       = 1'b1;
                end else begin
                    r_d   = r_nx;
                    q_d   = q_nx;
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d     = ST_DONE;
                        busy_d      = 1'b0;
                        quotient_d  = q_nx;
                        remainder_d = r_nx[WIDTH_D-1:0];
                        dbz_d       = 1'b0;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            r_q         <= '0;
            q_q         <= '0;
            dvs_q       <= '0;
            zero_q      <= 1'b0;
            busy_q      <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            r_q         <= r_d;
            q_q         <= q_d;
            dvs_q       <= dvs_d;
            zero_q      <= zero_d;
            busy_q      <= busy_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = (state_q == ST_DONE);
    assign bus.quotient    = quotient_q;
    assign bus.remainder   = remainder_q;
    assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_seq_div_8bit.sv
// tb/tb_seq_div_8bit.sv - self-checking bench for seq_div_8bit against an arithmetic reference model
module tb_seq_div_8bit;
    import div_pkg::*;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    seq_div_8bit_if bus ();

    seq_div_8bit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic void ref_div(input int a, input int b,
                                    output int q, output int r, output int z, output int lat);
        if (b == 0) begin
            q = 255; r = a % 16; z = 1; lat = 1;
        end else begin
            q = a / b; r = a % b; z = 0; lat = 8;
        end
    endfunction

    task automatic wait_done(output int lat);
        lat = 0;
        while (bus.done !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run_op(input int a, input int b);
        int q, r, z, lat_exp, lat;
        ref_div(a, b, q, r, z, lat_exp);
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = 8'(a);
        bus.divisor  = 4'(b);
        @(negedge clk);
        bus.start    = 1'b0;
        bus.dividend = 8'($urandom);
        bus.divisor  = 4'($urandom);
        check("busy_after_start", 32'(bus.busy), 32'(b != 0));
        wait_done(lat);
        check("latency", 32'(lat), 32'(lat_exp));
        check("quotient", 32'(bus.quotient), 32'(q));
        check("remainder", 32'(bus.remainder), 32'(r));
        check("div_by_zero", 32'(bus.div_by_zero), 32'(z));
        @(negedge clk);
        check("done_width", 32'(bus.done), 32'(0));
    endtask

    initial begin
        int lat, ndone, off, idx;

        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(bus.busy), 32'(0));
        check("rst_done", 32'(bus.done), 32'(0));
        check("rst_quotient", 32'(bus.quotient), 32'(0));
        check("rst_remainder", 32'(bus.remainder), 32'(0));
        check("rst_dbz", 32'(bus.div_by_zero), 32'(0));
        rst = 1'b0;

        run_op(117, 9);
        run_op(200, 7);
        run_op(255, 1);
        run_op(225, 15);
        run_op(8'h55, 0);

        // start during busy is ignored; start during DONE is accepted back-to-back
        @(negedge clk);
        bus.start = 1'b1; bus.dividend = 8'd20; bus.divisor = 4'd2;
        @(negedge clk);
        bus.start = 1'b0;
        check("ign_busy", 32'(bus.busy), 32'(1));
        @(negedge clk);
        @(negedge clk);
        bus.start = 1'b1; bus.dividend = 8'd9; bus.divisor = 4'd3;
        @(negedge clk);
        bus.start = 1'b0; bus.dividend = 8'd20; bus.divisor = 4'd2;
        wait_done(lat);
        check("ign_latency", 32'(lat), 32'(5));
        check("ign_quotient", 32'(bus.quotient), 32'(10));
        check("ign_remainder", 32'(bus.remainder), 32'(0));
        bus.start = 1'b1; bus.dividend = 8'd9; bus.divisor = 4'd3;
        @(negedge clk);
        bus.start = 1'b0; bus.dividend = 8'd0; bus.divisor = 4'd0;
        check("b2b_done_drop", 32'(bus.done), 32'(0));
        check("b2b_busy", 32'(bus.busy), 32'(1));
        check("b2b_held_quotient", 32'(bus.quotient), 32'(10));
        wait_done(lat);
        check("b2b_latency", 32'(lat), 32'(8));
        check("b2b_quotient", 32'(bus.quotient), 32'(3));
        check("b2b_remainder", 32'(bus.remainder), 32'(0));
        @(negedge clk);

        // reset mid-operation abandons the division
        @(negedge clk);
        bus.start = 1'b1; bus.dividend = 8'd117; bus.divisor = 4'd9;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mrst_busy", 32'(bus.busy), 32'(0));
        check("mrst_done", 32'(bus.done), 32'(0));
        check("mrst_quotient", 32'(bus.quotient), 32'(0));
        check("mrst_remainder", 32'(bus.remainder), 32'(0));
        check("mrst_dbz", 32'(bus.div_by_zero), 32'(0));
        ndone = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.done === 1'b1 || bus.busy === 1'b1) ndone++;
        end
        check("mrst_no_done", 32'(ndone), 32'(0));
        run_op(10, 3);

        // every operand pair once, visited in a random odd-stride order
        off = int'($urandom_range(0, 4095));
        for (int i = 0; i < 4096; i++) begin
            idx = (i * 1031 + off) % 4096;
            run_op(idx / 16, idx % 16);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
